lz4_sequence_parser: RTL

- Front-end stage that feeds the LZ4 decoder core.
- Consumes the raw compressed LZ4 block byte stream (from the UART RX FIFO or the Wishbone write path) and splits it into two streams: literal bytes and match commands (offset, length).
- The decoder's history RAM and copy engine consume both streams.
- Parses only the token / length-extension / offset fields of the block format; it does not handle frame headers or checksums.

---
 rtl/lz4_sequence_parser.sv | 120 ++++++++++++
 1 files changed

// File: rtl/lz4_sequence_parser.sv
// LZ4 block sequence parser: splits the compressed byte stream into a literal
// byte stream (zero-latency pass-through) and registered match commands.
module lz4_sequence_parser #(
    parameter int LEN_W = 16,
    parameter int OFF_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             lit_valid,
    output logic [7:0]       lit_data,
    input  logic             lit_ready,
    output logic             match_valid,
    output logic [OFF_W-1:0] match_offset,
    output logic [LEN_W-1:0] match_length,
    input  logic             match_ready,
    output logic             block_done,
    output logic             err
);
    localparam logic [2:0] S_TOKEN      = 3'd0;
    localparam logic [2:0] S_LIT_EXT    = 3'd1;
    localparam logic [2:0] S_LITERALS   = 3'd2;
    localparam logic [2:0] S_OFF_LO     = 3'd3;
    localparam logic [2:0] S_OFF_HI     = 3'd4;
    localparam logic [2:0] S_MATCH_EXT  = 3'd5;
    localparam logic [2:0] S_MATCH_EMIT = 3'd6;
    localparam logic [2:0] S_ERROR      = 3'd7;

    logic [2:0]       state;
    logic [LEN_W-1:0] lit_cnt;
    logic [LEN_W-1:0] mlen;
    logic [OFF_W-1:0] off_q;
    logic             mext;
    logic             in_fire;
    logic [LEN_W:0]   lit_sum;
    logic [LEN_W:0]   mlen_sum;
    logic [15:0]      off_full;

    always_comb begin
        in_ready = 1'b0;
        case (state)
            S_TOKEN, S_LIT_EXT, S_OFF_LO, S_OFF_HI, S_MATCH_EXT: in_ready = !rst;
            S_LITERALS:                                           in_ready = lit_ready && !rst;
            default:                                              in_ready = 1'b0;
        endcase
    end

    assign in_fire      = in_valid && in_ready;
    assign lit_valid    = (state == S_LITERALS) && in_valid;
    assign lit_data     = in_data;
    assign match_valid  = (state == S_MATCH_EMIT);
    assign match_offset = off_q;
    assign match_length = mlen;
    assign err          = (state == S_ERROR);

    // Extra carry bit detects length overflow past LEN_W.
    assign lit_sum  = {1'b0, lit_cnt} + (LEN_W+1)'(in_data);
    assign mlen_sum = {1'b0, mlen} + (LEN_W+1)'(in_data);
    assign off_full = {in_data, off_q[7:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_TOKEN;
            lit_cnt    <= '0;
            mlen       <= '0;
            off_q      <= '0;
            mext       <= 1'b0;
            block_done <= 1'b0;
        end else begin
            block_done <= 1'b0;
            case (state)
                S_TOKEN: if (in_fire) begin
                    lit_cnt <= LEN_W'(in_data[7:4]);
                    mlen    <= LEN_W'(in_data[3:0]) + LEN_W'(4);
                    mext    <= (in_data[3:0] == 4'hF);
                    if (in_last) begin
                        if (in_data[7:4] == 4'h0) block_done <= 1'b1;
                        else                      state      <= S_ERROR;
                    end else if (in_data[7:4] == 4'hF) state <= S_LIT_EXT;
                    else if (in_data[7:4] != 4'h0)     state <= S_LITERALS;
                    else                               state <= S_OFF_LO;
                end
                S_LIT_EXT: if (in_fire) begin
                    lit_cnt <= lit_sum[LEN_W-1:0];
                    if (in_last || lit_sum[LEN_W]) state <= S_ERROR;
                    else if (in_data != 8'hFF)     state <= S_LITERALS;
                end
                S_LITERALS: if (in_fire) begin
                    lit_cnt <= lit_cnt - LEN_W'(1);
                    if (lit_cnt == LEN_W'(1)) begin
                        if (in_last) begin
                            block_done <= 1'b1;
                            state      <= S_TOKEN;
                        end else state <= S_OFF_LO;
                    end else if (in_last) state <= S_ERROR;
                end
                S_OFF_LO: if (in_fire) begin
                    off_q <= OFF_W'(in_data);
                    state <= in_last ? S_ERROR : S_OFF_HI;
                end
                S_OFF_HI: if (in_fire) begin
                    off_q <= OFF_W'(off_full);
                    if (in_last || off_full == 16'd0) state <= S_ERROR;
                    else if (mext)                    state <= S_MATCH_EXT;
                    else                              state <= S_MATCH_EMIT;
                end
                S_MATCH_EXT: if (in_fire) begin
                    mlen <= mlen_sum[LEN_W-1:0];
                    if (in_last || mlen_sum[LEN_W]) state <= S_ERROR;
                    else if (in_data != 8'hFF)      state <= S_MATCH_EMIT;
                end
                S_MATCH_EMIT: if (match_ready) state <= S_TOKEN;
                default: ;
            endcase
        end
    end
endmodule
